elastic_fifo_xform: RTL
=======================

Name: elastic_fifo_xform

Overview:
- Parametrised multi-entry elastic buffer with valid/ready handshake on both sides.
- Applies a per-word selectable shift transform at write time.
- Successor to the single-stage elastic shift-by-two stage: generalised width, depth, shift amount and transform mode, plus occupancy reporting and synchronous flush.
- Sits between a producer (t0 side) and a consumer (i0 side) on any streaming datapath needing rate decoupling.

Parameters:
- WIDTH, 32: data width in bits, >= 2.
- DEPTH, 4: number of storage entries, >= 1. Need not be a power of two.
- SHIFT, 2: shift amount for the transform modes. Legal range 0 <= SHIFT < WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstf  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous clear of all buffered words.
- t0_data  input  WIDTH  producer data.
- t0_mode  input  2  transform select, sampled with t0_data: 0 pass, 1 shift-left, 2 logical shift-right, 3 arithmetic shift-right.
- t0_valid  input  1  producer data valid.
- t0_ready  output  1  buffer can accept a word this cycle.
- i0_data  output  WIDTH  head-of-buffer data, already transformed.
- i0_valid  output  1  head word valid.
- i0_ready  input  1  consumer accepts head word.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rstf low, asynchronous): count=0, read/write pointers=0, all storage entries=0, i0_valid=0, i0_data=0. t0_ready=0 combinationally for as long as rstf is low.
- t0_ready = rstf & ~flush & ((count < DEPTH) | i0_ready). This is combinational from i0_ready, so a full buffer accepts a word in the same cycle the head is popped.
- push = t0_valid & t0_ready; pop = i0_valid & i0_ready.
- i0_valid = (count != 0).
- i0_data = storage[rd_ptr]. It must hold stable while i0_valid & ~i0_ready.
- Transform is applied on write and stored already transformed:
  - mode 0: t0_data.
  - mode 1: t0_data << SHIFT; upper bits discarded, zero fill.
  - mode 2: t0_data >> SHIFT; zero fill.
  - mode 3: t0_data >>> SHIFT; fill with t0_data[WIDTH-1].
  - Result width is always WIDTH.
- Latency: a word pushed at edge N is visible on i0 after edge N. There is no same-cycle bypass, so minimum latency is 1 cycle.
- Throughput: 1 word/cycle sustained when both sides are ready.
- Pointers advance by 1 on push (wr_ptr) and on pop (rd_ptr), wrapping from DEPTH-1 to 0 explicitly.
- count update: +1 on push only; -1 on pop only; unchanged on push & pop or on neither.
- Full (count=DEPTH):
  - with i0_ready=1: push and pop proceed together, count stays DEPTH.
  - with i0_ready=0: t0_ready=0.
- Empty (count=0): i0_valid=0, so pop is impossible. A push increments count to 1.
- Flush (flush=1, synchronous):
  - t0_ready=0 that cycle, so no push.
  - At the next edge count=0 and both pointers=0; storage contents are not cleared.
  - A pop handshake in the flush cycle is honoured on the consumer side, but the word is discarded with the rest. i0_valid is 0 the cycle after flush.
- Flush has lower priority than rstf. Flush with the buffer already empty is a no-op.
- Reset mid-operation: all buffered words are lost; outputs take reset values immediately, without waiting for clk.
- The first push after rstf release is accepted on the first edge with rstf high.
- DEPTH=1 with t0_mode tied to 1 and SHIFT=2 is cycle-equivalent to the existing single-stage elastic shift stage.

Test Plan (WIDTH=32, DEPTH=4, SHIFT=2):
- Reset: hold rstf=0, t0_valid=1 -> t0_ready=0, i0_valid=0, i0_data=0x00000000, count=0. Release rstf -> t0_ready=1 next cycle.
- Modes, i0_ready=1; push in order:
  - 0x00000001 m0 -> 0x00000001.
  - 0x40000001 m1 -> 0x00000004.
  - 0x80000010 m2 -> 0x20000004.
  - 0x80000010 m3 -> 0xE0000004.
  - Each output appears 1 cycle after acceptance, in order.
- Fill/backpressure: i0_ready=0, offer 0xA0..0xA4 on consecutive cycles, mode 0 -> first four accepted, count=4, t0_ready=0 while 0xA4 is held. Raise i0_ready=1 -> 0xA4 accepted in the same cycle 0xA0 pops; count stays 4; outputs 0xA0, 0xA1, 0xA2, 0xA3, 0xA4.
- Streaming: t0_valid=1 and i0_ready=1 for 100 incrementing words -> no drops, no reorder, count <= 1 throughout, one output per cycle after the first.
- Random stall: randomised t0_valid and i0_ready for 10k cycles against a scoreboard -> exact order match, count equals the scoreboard depth every cycle, count never exceeds 4.
- Flush and async reset:
  - With count=3, assert flush for 1 cycle with t0_valid=1 -> no push that cycle; next cycle count=0, i0_valid=0.
  - With count=2, drop rstf between edges -> i0_valid=0 and count=0 immediately. After release, push 0x5 mode 1 -> i0_data=0x14 next cycle.

Source files
------------

// File: rtl/elastic_fifo_xform.sv
// Multi-entry elastic buffer with valid/ready on both sides; each word is shifted
// (pass / left / logical right / arithmetic right) at write time and stored transformed.
module elastic_fifo_xform #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SHIFT = 2
) (
    input  logic                       clk,
    input  logic                       rstf,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           t0_data,
    input  logic [1:0]                 t0_mode,
    input  logic                       t0_valid,
    output logic                       t0_ready,
    output logic [WIDTH-1:0]           i0_data,
    output logic                       i0_valid,
    input  logic                       i0_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    if (WIDTH < 2 || DEPTH < 1 || SHIFT >= WIDTH) begin : g_param_check
        $error("elastic_fifo_xform: illegal WIDTH/DEPTH/SHIFT");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] xform;
    logic             push, pop;

    // A full buffer still accepts when the head is popped in the same cycle.
    assign t0_ready = rstf & ~flush & ((count_q < FULL) | i0_ready);
    assign i0_valid = (count_q != '0);
    assign i0_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

    assign push = t0_valid & t0_ready;
    assign pop  = i0_valid & i0_ready;

    always_comb begin
        xform = t0_data;
        unique case (t0_mode)
            2'd0: xform = t0_data;
            2'd1: xform = t0_data << SHIFT;
            2'd2: xform = t0_data >> SHIFT;
            2'd3: xform = $signed(t0_data) >>> SHIFT;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Flush drops everything, including a word popped this same cycle.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= xform;
        end
    end

endmodule
